// File: rtl/ps2_rx_fifo_pkg.sv
// PS/2 receiver shared types and helpers.
// Frame layout constants and the parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  function automatic logic odd_parity_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchroniser plus run-length
// glitch filter; output moves only after FILT_LEN equal samples.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic RESET_N,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILT_LEN);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      dout <= 1'b1;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 != dout) begin
        if (cnt == CW'(FILT_LEN - 1)) begin
          dout <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: deframer, parity/stop checks,
// timeout, scan-code FIFO and sticky error flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                            clk_sys,
  input  logic                            RESET_N,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            rd,
  output logic [7:0]                      dout,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow,
  input  logic                            clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_f;
  logic data_f;
  logic clk_q;
  logic fall;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .RESET_N (RESET_N),
    .din     (ps2_clk),
    .dout    (clk_f)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
    .clk_sys (clk_sys),
    .RESET_N (RESET_N),
    .din     (ps2_data),
    .dout    (data_f)
  );

  assign fall = clk_q & ~clk_f;

  ps2_state_t    state;
  ps2_state_t    state_n;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          push;
  logic          set_perr;
  logic          set_ferr;

  assign tmo_hit = (state != IDLE) && !fall &&
                   (tmo == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          if (!data_f) state_n = DATA;
          else         set_ferr = 1'b1;
        end
      end
      DATA: begin
        if (fall && bit_idx == 3'(PS2_DATA_BITS - 1))
          state_n = PARITY;
      end
      PARITY: begin
        if (fall) state_n = STOP;
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (!data_f)
            set_ferr = 1'b1;
          else if (!odd_parity_ok(shreg, par))
            set_perr = 1'b1;
          else
            push = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Stalled partial frame: drop it and flag a framing error
    if (tmo_hit) begin
      state_n  = IDLE;
      set_ferr = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo     <= '0;
      clk_q   <= 1'b1;
    end else begin
      state <= state_n;
      clk_q <= clk_f;
      tmo   <= (fall || state == IDLE) ? '0 : tmo + TW'(1);
      if (fall) begin
        case (state)
          IDLE: bit_idx <= '0;
          DATA: begin
            shreg   <= {data_f, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY: par <= data_f;
          default: ;
        endcase
      end
    end
  end

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        do_rd;
  logic        do_wr;
  logic [7:0]  last_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_rd = rd && !empty;
  assign do_wr = push && (!full || do_rd);
  assign count = CW'(wr_ptr - rd_ptr);
  assign dout  = empty ? last_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      last_q <= dout;
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (set_perr)     parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (set_ferr)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (push && full && !do_rd) overflow <= 1'b1;
      else if (clr_err)           overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed and random frames against a queue-based model
// of the PS/2 receiver FIFO.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;

  logic       clk_sys  = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd       = 1'b0;
  logic       clr_err  = 1'b0;
  logic [7:0] dout;
  logic       empty;
  logic [2:0] count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  always #5 clk_sys = ~clk_sys;

  ps2_rx_fifo #(
    .FILT_LEN    (8),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (RESET_N),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd         (rd),
    .dout       (dout),
    .empty      (empty),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  logic [7:0] q[$];
  logic [7:0] last;
  bit m_perr, m_ferr, m_ovf;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic model_reset();
    q.delete();
    last   = 8'h00;
    m_perr = 0;
    m_ferr = 0;
    m_ovf  = 0;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_d;
    @(negedge clk_sys);
    exp_d = (q.size() != 0) ? q[0] : last;
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".dout"},  32'(dout),  32'(exp_d));
    chk({tag, ".perr"},  32'(parity_err), 32'(m_perr));
    chk({tag, ".ferr"},  32'(frame_err),  32'(m_ferr));
    chk({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
  endtask

  task automatic pop();
    @(negedge clk_sys);
    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
    if (q.size() != 0) last = q.pop_front();
  endtask

  task automatic clear_flags();
    @(negedge clk_sys);
    clr_err = 1'b1;
    @(negedge clk_sys);
    clr_err = 1'b0;
    m_perr = 0;
    m_ferr = 0;
    m_ovf  = 0;
  endtask

  // hp = clock-low length; bit period is 2*hp cycles
  task automatic send_frame(input logic [7:0] b, input bit bad_start,
                            input bit bad_par, input bit bad_stop,
                            input int hp, input int nbits,
                            input int glitch_bit, input bit rd_on_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, bad_start};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_bit) begin
        wait_cyc(hp / 4);
        ps2_data = ~f[i];
        wait_cyc(5);
        ps2_data = f[i];
        wait_cyc(hp / 2 - hp / 4 - 5);
      end else begin
        wait_cyc(hp / 2);
      end
      ps2_clk = 1'b0;
      if (rd_on_stop && i == 10) begin
        repeat (10) @(posedge clk_sys);
        @(negedge clk_sys);
        rd = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
        wait_cyc(hp - 11);
      end else begin
        wait_cyc(hp);
      end
      ps2_clk = 1'b1;
      wait_cyc(hp / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input bit rd_on_stop);
    if (rd_on_stop && q.size() != 0) last = q.pop_front();
    if (bad_stop)               m_ferr = 1;
    else if (bad_par)           m_perr = 1;
    else if (q.size() == DEPTH) m_ovf  = 1;
    else                        q.push_back(b);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par,
                       input bit bad_stop, input int hp);
    send_frame(b, 0, bad_par, bad_stop, hp, 11, -1, 0);
    model_frame(b, bad_par, bad_stop, 0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         rp;
    int         np;
    model_reset();
    wait_cyc(5);
    check_all("reset");
    RESET_N = 1'b1;
    wait_cyc(20);

    frame(8'h1C, 0, 0, 200);
    check_all("good_1c");
    pop();
    check_all("good_1c_pop");

    frame(8'h1C, 1, 0, 200);
    check_all("bad_par");
    clear_flags();
    check_all("bad_par_clr");

    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check_all("clk_glitch");
    send_frame(8'h1C, 0, 0, 0, 200, 11, 3, 0);
    model_frame(8'h1C, 0, 0, 0);
    check_all("data_glitch");
    pop();

    send_frame(8'h00, 1, 0, 0, 100, 1, -1, 0);
    m_ferr = 1;
    check_all("bad_start");
    clear_flags();
    frame(8'h33, 0, 1, 100);
    check_all("bad_stop");
    clear_flags();

    for (int i = 1; i <= 5; i++) frame(8'(i), 0, 0, 100);
    check_all("ovf");
    for (int i = 0; i < 4; i++) begin
      pop();
      check_all("ovf_pop");
    end
    clear_flags();

    send_frame(8'h5A, 0, 0, 0, 100, 5, -1, 0);
    wait_cyc(2600);
    m_ferr = 1;
    check_all("timeout");
    frame(8'hF0, 0, 0, 100);
    check_all("after_tmo");
    pop();
    clear_flags();

    for (int i = 0; i < 4; i++) frame(8'h11 + 8'(i), 0, 0, 100);
    check_all("refill");
    send_frame(8'hAA, 0, 0, 0, 100, 11, -1, 1);
    model_frame(8'hAA, 0, 0, 1);
    check_all("full_rd");
    for (int i = 0; i < 4; i++) begin
      pop();
      check_all("full_rd_pop");
    end

    frame(8'h42, 0, 0, 100);
    send_frame(8'h77, 0, 0, 0, 100, 4, -1, 0);
    @(negedge clk_sys);
    RESET_N = 1'b0;
    model_reset();
    wait_cyc(3);
    check_all("mid_rst");
    RESET_N = 1'b1;
    wait_cyc(20);
    frame(8'h5A, 0, 0, 100);
    check_all("post_rst");
    pop();

    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      rp = ($urandom_range(0, 3) == 0);
      frame(rb, rp, 0, 50);
      check_all("rand");
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) begin
        pop();
        check_all("rand_pop");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver with a scan-code FIFO for the MultiComp core. It replaces the bare single-byte PS/2 path into the Microcomputer keyboard interface. It samples the hps_io PS/2 clock and data outputs and filters glitches. It deframes 11-bit PS/2 frames, checks odd parity and the stop bit, and buffers up to FIFO_DEPTH bytes for the CPU-side reader. It reports sticky parity, framing and overflow errors.

Parameters:
FILT_LEN, 8, consecutive identical samples needed before a filtered PS/2 line changes (range 2..64)
FIFO_DEPTH, 16, scan-code entries; power of two, at least 2
TIMEOUT_CYC, 50000, clk_sys cycles without a falling PS/2 clock edge before a partial frame is abandoned (1 ms at 50 MHz)

Ports:
clk_sys  in  1  system clock, the same clock as hps_io and Microcomputer
RESET_N  in  1  asynchronous active-low reset
ps2_clk  in  1  PS/2 clock from hps_io (asynchronous)
ps2_data  in  1  PS/2 data from hps_io (asynchronous)
rd  in  1  pop strobe, one entry per cycle while high
dout  out  8  head-of-FIFO byte, show-ahead
empty  out  1  FIFO empty
count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
parity_err  out  1  sticky: frame rejected for bad parity
frame_err  out  1  sticky: bad start bit, bad stop bit or timeout
overflow  out  1  sticky: byte dropped because the FIFO was full
clr_err  in  1  clears all three sticky flags

Behaviour:
- Reset (async assert, sync release on clk_sys):
  - FSM in IDLE; FIFO pointers 0; count 0; empty 1; dout 0.
  - All error flags 0; filter outputs 1; timeout counter 0.
- Input conditioning, per line:
  - 2-FF synchroniser, then a saturating run counter.
  - The filtered output takes the synchronised value after FILT_LEN consecutive equal samples.
  - fall = filtered clock was 1 last cycle and is 0 now. Data is sampled from filtered data on fall.
- FSM states:
  - IDLE: on fall, if data=0 go to DATA with bit index 0. If data=1, stay in IDLE and set frame_err.
  - DATA: on each fall, shift data in LSB first. After bit 7 go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, return to IDLE.
    - If data=0, set frame_err.
    - Else if XOR of the 8 data bits and the parity bit is 0, set parity_err.
    - Otherwise issue a push of the byte.
  - No frame is pushed on any error.
- Timeout:
  - Counter clears on every fall and in IDLE.
  - In DATA, PARITY or STOP, reaching TIMEOUT_CYC forces IDLE and sets frame_err. The partial byte is discarded.
- Latency: empty deasserts and dout is valid in the cycle after the fall that completes a good STOP.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of $clog2(FIFO_DEPTH)+1 bits each. The MSB distinguishes full from empty.
  - dout = mem[rd_ptr] whenever empty=0. dout holds its last value when empty.
  - rd while empty is ignored; no underflow flag.
  - A push while full with no rd drops the byte and sets overflow. Stored data is unchanged.
  - A push and rd in the same cycle while full both take effect; count is unchanged and overflow is not set.
  - A push and rd in the same cycle while empty: the push lands and rd is ignored.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Sticky flags:
  - Set and clear are registered.
  - If clr_err and a new error happen in the same cycle, the set wins.
- Mid-frame reset: partial frame lost, FIFO emptied, FSM in IDLE. After release the receiver accepts the next start bit normally.

Decomposition:
- Package ps2_pkg:
  - State enum {IDLE, DATA, PARITY, STOP}.
  - Constants PS2_DATA_BITS=8 and PS2_FRAME_BITS=11.
  - Function odd_parity_ok(byte, p).
- Sub-module ps2_line_filter(clk_sys, RESET_N, din, dout), parameter FILT_LEN. Instantiated twice, once per line.
- FIFO, FSM and timeout logic live inline in ps2_rx_fifo.

Test Plan:
- Frame 0x1C with parity 0 (bit period 400 cycles, FILT_LEN 8) -> empty=0, count=1, dout=0x1C, no flags. rd for 1 cycle -> empty=1, count=0.
- Frame 0x1C with parity 1 -> count stays 0, parity_err=1. clr_err -> parity_err=0.
- FIFO_DEPTH=4, frames 0x01..0x05 with no rd -> count=4, overflow=1, dout=0x01. Four pops yield 0x01,0x02,0x03,0x04.
- 3-cycle low glitch on ps2_clk in IDLE -> no state change, no flag. A 5-cycle glitch on ps2_data mid-bit -> byte still 0x1C.
- Start plus 4 data bits, then silence for TIMEOUT_CYC (2000 in sim) -> frame_err=1, FSM IDLE. A following full frame 0xF0 (parity 1) -> dout=0xF0.
- FIFO full (DEPTH=4) with rd asserted in the completing cycle of a 5th frame 0xAA -> count stays 4, overflow=0, last entry 0xAA. RESET_N low mid-frame -> count=0, empty=1.
